// File: rtl/pipeline_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package pipeline_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    // x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Data-memory request/ready handshake between the controller and the memory.
interface pipeline_ctrl_if;
    logic dmem_valid;
    logic dmem_ready;

    modport master (output dmem_valid, input dmem_ready);
    modport slave  (input dmem_valid, output dmem_ready);
endinterface

// File: rtl/hazard_fwd_unit.sv
// Per-operand forwarding select; the Memory stage wins over Writeback.
module hazard_fwd_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       regwrite_m,
    input  logic [4:0] rd_w,
    input  logic       regwrite_w,
    output logic [1:0] fwd
);
    always_comb begin
        fwd = FWD_RF;
        if (regwrite_m && reg_match(rs, rd_m)) begin
            fwd = FWD_M;
        end else if (regwrite_w && reg_match(rs, rd_w)) begin
            fwd = FWD_W;
        end
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stall/flush/forward decisions, a data-memory wait
// FSM with timeout detection, and saturating performance counters.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [1:0]       ResultSrc_e,
    input  logic             PCSrc_e,
    input  logic [4:0]       rd_m,
    input  logic             RegWrite_m,
    input  logic             MemAccess_m,
    input  logic [4:0]       rd_w,
    input  logic             RegWrite_w,
    pipeline_ctrl_if.master  dmem,
    output logic             pc_en,
    output logic             en_fd,
    output logic             en_de,
    output logic             en_em,
    output logic             en_mw,
    output logic             clr_fd,
    output logic             clr_de,
    output logic             clr_em,
    output logic             clr_mw,
    output logic [1:0]       ForwardA_e,
    output logic [1:0]       ForwardB_e,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_err
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0]  stall_cycles_reg;
    logic [CNT_W-1:0]  flush_count_reg;
    logic              mem_err_reg;
    logic              mem_stall;
    logic              load_use;
    logic              flush_applied;
    logic [4:0]        rs_e_arr [2];
    logic [1:0]        fwd_arr  [2];

    assign dmem.dmem_valid = MemAccess_m & ~rst;
    assign mem_stall       = dmem.dmem_valid & ~dmem.dmem_ready;
    assign load_use        = (ResultSrc_e == RESULT_LOAD) &&
                             (reg_match(rd_e, rs1_d) || reg_match(rd_e, rs2_d));
    // A flush raised during a memory stall is held by Execute until release.
    assign flush_applied   = PCSrc_e & ~mem_stall & ~rst;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:  if (mem_stall)  state_next = ST_WAIT;
            ST_WAIT: if (!mem_stall) state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        pc_en  = 1'b1;
        en_fd  = 1'b1;
        en_de  = 1'b1;
        en_em  = 1'b1;
        en_mw  = 1'b1;
        clr_fd = 1'b0;
        clr_de = 1'b0;
        clr_em = 1'b0;
        clr_mw = 1'b0;
        if (rst) begin
            pc_en  = 1'b0;
            clr_fd = 1'b1;
            clr_de = 1'b1;
            clr_em = 1'b1;
            clr_mw = 1'b1;
        end else if (mem_stall) begin
            // Freeze F..M; the instruction leaving M is replaced by a bubble in W.
            pc_en  = 1'b0;
            en_fd  = 1'b0;
            en_de  = 1'b0;
            en_em  = 1'b0;
            clr_mw = 1'b1;
        end else if (PCSrc_e) begin
            clr_fd = 1'b1;
            clr_de = 1'b1;
        end else if (load_use) begin
            pc_en  = 1'b0;
            en_fd  = 1'b0;
            clr_de = 1'b1;
        end
    end

    assign rs_e_arr[0] = rs1_e;
    assign rs_e_arr[1] = rs2_e;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            hazard_fwd_unit u_fwd (
                .rs         (rs_e_arr[gi]),
                .rd_m       (rd_m),
                .regwrite_m (RegWrite_m),
                .rd_w       (rd_w),
                .regwrite_w (RegWrite_w),
                .fwd        (fwd_arr[gi])
            );
        end
    endgenerate

    assign ForwardA_e = rst ? FWD_RF : fwd_arr[0];
    assign ForwardB_e = rst ? FWD_RF : fwd_arr[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_RUN;
            wait_cnt_reg     <= '0;
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
            mem_err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_RUN) begin
                wait_cnt_reg <= '0;
            end else if (wait_cnt_reg != WAIT_W'(TIMEOUT)) begin
                wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
            end
            if (state_reg == ST_WAIT && wait_cnt_reg == WAIT_W'(TIMEOUT - 1)) begin
                mem_err_reg <= 1'b1;
            end
            if (!pc_en && stall_cycles_reg != '1) begin
                stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
            end
            if (flush_applied && flush_count_reg != '1) begin
                flush_count_reg <= flush_count_reg + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;
    assign mem_err      = mem_err_reg;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the saturating performance counters.
REQ-002 Parameter: TIMEOUT, 255, number of WAIT cycles before mem_err is set.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rs1_d, rs2_d  in  5 each  Decode-stage source registers.
REQ-006 rs1_e, rs2_e, rd_e  in  5 each  Execute-stage sources and destination.
REQ-007 ResultSrc_e  in  2  Execute result select; RESULT_LOAD marks a load.
REQ-008 PCSrc_e  in  1  taken branch/jump resolved in Execute.
REQ-009 rd_m, RegWrite_m, MemAccess_m  in  5/1/1  Memory-stage destination, write-back enable, load/store present.
REQ-010 rd_w, RegWrite_w  in  5/1  Writeback-stage destination and write-back enable.
REQ-011 dmem_ready  in  1  data memory completes the transfer this cycle.
REQ-012 dmem_valid  out  1  data memory request pending.
REQ-013 pc_en  out  1  PC register load enable.
REQ-014 en_fd, en_de, en_em, en_mw  out  1 each  pipeline-register enables.
REQ-015 clr_fd, clr_de, clr_em, clr_mw  out  1 each  pipeline-register flushes.
REQ-016 ForwardA_e, ForwardB_e  out  2 each  00 register file, 10 from M, 01 from W.
REQ-017 stall_cycles, flush_count  out  CNT_W each  performance counters.
REQ-018 mem_err  out  1  sticky memory-timeout flag.

Function
REQ-019 dmem_valid SHALL equal MemAccess_m while rst is low.
REQ-020 FSM states SHALL be RUN and WAIT.
REQ-021 RUN->WAIT when dmem_valid=1 and dmem_ready=0.
REQ-022 WAIT->RUN on the cycle dmem_ready=1.
REQ-023 mem_stall = dmem_valid & ~dmem_ready, in either state.
REQ-024 While mem_stall: pc_en=en_fd=en_de=en_em=0, all other clr_* =0, en_mw=1 and clr_mw=1 (bubble into W).
REQ-025 Load-use hazard when ResultSrc_e==RESULT_LOAD, rd_e!=0 and rd_e matches rs1_d or rs2_d.
REQ-026 On a load-use hazard (no mem_stall): pc_en=0, en_fd=0, clr_de=1; all other enables 1; exactly one bubble.
REQ-027 On PCSrc_e (no mem_stall): clr_fd=1, clr_de=1, pc_en=1.
REQ-028 If PCSrc_e and a load-use hazard occur in the same cycle, the flush SHALL win and no stall is applied.
REQ-029 A flush during mem_stall SHALL be deferred; it takes effect on the release cycle because PCSrc_e is held.
REQ-030 With no hazard: all en_*=1, all clr_*=0, pc_en=1.
REQ-031 Forwarding, per operand: rs_e!=0 and matches rd_m with RegWrite_m -> 10; else matches rd_w with RegWrite_w -> 01; else 00. M has priority over W.
REQ-032 Register x0 SHALL never match for either hazard detection or forwarding.
REQ-033 stall_cycles SHALL increment on every cycle with pc_en=0 while rst is low, saturating at all-ones.
REQ-034 flush_count SHALL increment on every applied (not deferred) PCSrc_e flush, saturating at all-ones.
REQ-035 wait_cnt SHALL clear in RUN and increment in WAIT.
REQ-036 When wait_cnt reaches TIMEOUT, mem_err SHALL set and stay set until reset; the stall continues.
REQ-037 dmem_ready while dmem_valid=0 SHALL be ignored.

Reset
REQ-038 While rst is high: state=RUN; wait_cnt, stall_cycles, flush_count and mem_err =0; dmem_valid=0; pc_en=0; all en_*=1; all clr_*=1; Forward*=00.
REQ-039 Reset asserted in WAIT SHALL return the FSM to RUN on the next edge and drop the pending request.

Structure
REQ-040 pipeline_pkg SHALL hold the state enum, the forward-select encodings (FWD_RF, FWD_M, FWD_W) and RESULT_LOAD=2'b01.
REQ-041 Forwarding SHALL live in a combinational sub-module, hazard_fwd_unit, instantiated once per operand.

Verification
REQ-042 Load x5 in E, rs1_d=5 -> one cycle with pc_en=0, en_fd=0, clr_de=1; stall_cycles +1.
REQ-043 PCSrc_e=1 with a simultaneous load-use match -> clr_fd=clr_de=1, pc_en=1; flush_count +1; stall_cycles unchanged.
REQ-044 MemAccess_m=1, dmem_ready low 3 cycles then high -> 3 frozen cycles with clr_mw=1, state WAIT, then release; stall_cycles +3.
REQ-045 rs1_e=rd_m=rd_w=7, both RegWrite=1 -> ForwardA_e=10; repeat with rd_m=0 -> ForwardA_e=01.
REQ-046 dmem_ready held low for 255 WAIT cycles -> mem_err=1 and pc_en still 0; rst pulse -> mem_err=0, state RUN.
REQ-047 Force stall_cycles to all-ones and stall again -> value stays all-ones.
